// File: rtl/plab5_mcore_mem_bank_responder_sep.sv
// Memory-bank endpoint for the split control/data memory network: services
// read/write/init requests against a domain-tagged word store, 2-entry response queue.
module plab5_mcore_mem_bank_responder_sep #(
  parameter int p_mem_opaque_nbits = 8,
  parameter int p_mem_addr_nbits   = 32,
  parameter int p_mem_data_nbits   = 32,
  parameter int p_num_words        = 16,
  localparam int RQC = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + 2,
  localparam int RSC = 3 + p_mem_opaque_nbits + 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [RQC-1:0]              req_msg_control,
  input  logic [p_mem_data_nbits-1:0] req_msg_data,
  input  logic                        req_domain,
  input  logic                        req_val,
  output logic                        req_rdy,
  output logic [RSC-1:0]              resp_msg_control,
  output logic [p_mem_data_nbits-1:0] resp_msg_data,
  output logic                        resp_domain,
  output logic                        resp_val,
  input  logic                        resp_rdy
);

  localparam int O     = p_mem_opaque_nbits;
  localparam int A     = p_mem_addr_nbits;
  localparam int D     = p_mem_data_nbits;
  localparam int IW    = $clog2(p_num_words);
  localparam int ENT_W = RSC + D + 1;

  localparam logic [2:0] TYPE_READ  = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;
  localparam logic [2:0] TYPE_INIT  = 3'd2;

  // Request field decode
  logic [2:0]    req_type;
  logic [O-1:0]  req_opaque;
  logic [A-1:0]  req_addr;
  logic [1:0]    req_len;
  logic [IW-1:0] req_idx;

  assign {req_type, req_opaque, req_addr, req_len} = req_msg_control;
  assign req_idx = req_addr[IW+1:2];

  // Byte offset and high address bits only select nothing; fold them away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[A-1:IW+2], req_addr[1:0]};

  // Handshake
  logic [1:0] count_q, count_d;
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic       resp_val_q, resp_val_d;
  logic       req_fire;
  logic       resp_pop;

  assign req_rdy  = ~count_q[1];
  assign req_fire = req_val & req_rdy;
  assign resp_pop = resp_val_q & resp_rdy;

  // Storage read side and access permission
  logic [D-1:0]           mem_rd [p_num_words];
  logic [p_num_words-1:0] tag_rd;
  logic [D-1:0]           rd_word;
  logic                   access_ok;

  assign rd_word   = mem_rd[req_idx];
  assign access_ok = ~tag_rd[req_idx] | req_domain;

  logic         store_en;
  logic [D-1:0] rsp_data;

  always_comb begin
    store_en = 1'b0;
    rsp_data = '0;
    case (req_type)
      TYPE_READ:  rsp_data = access_ok ? rd_word : '0;
      TYPE_WRITE: store_en = req_fire & access_ok;
      TYPE_INIT:  store_en = req_fire;
      default:    ;
    endcase
  end

  // One register pair per word; a write claims the word for the writer's domain.
  generate
    for (genvar gi = 0; gi < p_num_words; gi++) begin : g_word
      logic [D-1:0] word_q, word_d;
      logic         tag_bit_q, tag_bit_d;

      always_comb begin
        word_d    = word_q;
        tag_bit_d = tag_bit_q;
        if (store_en && (req_idx == IW'(gi))) begin
          word_d    = req_msg_data;
          tag_bit_d = req_domain;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          word_q    <= '0;
          tag_bit_q <= 1'b0;
        end else begin
          word_q    <= word_d;
          tag_bit_q <= tag_bit_d;
        end
      end

      assign mem_rd[gi] = word_q;
      assign tag_rd[gi] = tag_bit_q;
    end
  endgenerate

  // Response queue
  logic [ENT_W-1:0] new_ent;
  logic [ENT_W-1:0] ent_q [2];
  logic [ENT_W-1:0] ent_d [2];
  logic [ENT_W-1:0] out_q, out_d;

  assign new_ent = {req_type, req_opaque, req_len, rsp_data, req_domain};

  always_comb begin
    count_d  = count_q + {1'b0, req_fire} - {1'b0, resp_pop};
    head_d   = head_q ^ resp_pop;
    tail_d   = tail_q ^ req_fire;
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    if (req_fire) begin
      ent_d[tail_q] = new_ent;
    end
    // Output register tracks the head after this edge; holds its value when empty.
    resp_val_d = (count_d != 2'd0);
    out_d      = resp_val_d ? ent_d[head_d] : out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      ent_q[0]   <= '0;
      ent_q[1]   <= '0;
      out_q      <= '0;
      resp_val_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ent_q[0]   <= ent_d[0];
      ent_q[1]   <= ent_d[1];
      out_q      <= out_d;
      resp_val_q <= resp_val_d;
    end
  end

  assign {resp_msg_control, resp_msg_data, resp_domain} = out_q;
  assign resp_val = resp_val_q;

endmodule

// File: tb/tb_plab5_mcore_mem_bank_responder_sep.sv
// Directed bench for the domain-tagged memory bank responder: a queue/array model
// predicts every response, plus literal expectations for the directed scenarios.
module tb_plab5_mcore_mem_bank_responder_sep;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [44:0] req_msg_control;
  logic [31:0] req_msg_data;
  logic        req_domain;
  logic        req_val;
  logic        req_rdy;
  logic [12:0] resp_msg_control;
  logic [31:0] resp_msg_data;
  logic        resp_domain;
  logic        resp_val;
  logic        resp_rdy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rix         = 0;

  plab5_mcore_mem_bank_responder_sep dut (
    .clk              (clk),
    .reset            (reset),
    .req_msg_control  (req_msg_control),
    .req_msg_data     (req_msg_data),
    .req_domain       (req_domain),
    .req_val          (req_val),
    .req_rdy          (req_rdy),
    .resp_msg_control (resp_msg_control),
    .resp_msg_data    (resp_msg_data),
    .resp_domain      (resp_domain),
    .resp_val         (resp_val),
    .resp_rdy         (resp_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] rc(input logic [2:0] t, input logic [7:0] o, input logic [1:0] l);
    return {t, o, l};
  endfunction

  // Behavioural model: expected-response queue and a tagged word store
  typedef struct packed {
    logic [12:0] ctl;
    logic [31:0] data;
    logic        dom;
  } rsp_t;

  rsp_t        mq [$];
  logic [31:0] m_mem [N];
  logic        m_tag [N];
  logic [12:0] log_ctl [$];
  logic [31:0] log_data [$];
  logic        log_dom [$];
  int          log_cyc [$];

  bit          m_fire, m_pop, m_hidden;
  logic [2:0]  m_t;
  logic [3:0]  m_ix;
  logic [31:0] m_rd;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_resp_val", resp_val, 1'b0);
      check("rst_req_rdy", req_rdy, 1'b1);
      mq.delete();
      for (int i = 0; i < N; i++) begin
        m_mem[i] = 32'h0;
        m_tag[i] = 1'b0;
      end
    end else begin
      m_fire = req_val && (mq.size() < 2);
      m_pop  = (mq.size() != 0) && resp_rdy;
      check("resp_val", resp_val, mq.size() != 0);
      check("req_rdy", req_rdy, mq.size() < 2);
      if (mq.size() != 0) begin
        check("resp_ctl", resp_msg_control, mq[0].ctl);
        check("resp_data", resp_msg_data, mq[0].data);
        check("resp_dom", resp_domain, mq[0].dom);
      end
      if (resp_val && resp_rdy) begin
        log_ctl.push_back(resp_msg_control);
        log_data.push_back(resp_msg_data);
        log_dom.push_back(resp_domain);
        log_cyc.push_back(cyc);
      end
      if (m_pop) void'(mq.pop_front());
      if (m_fire) begin
        m_t      = req_msg_control[44:42];
        m_ix     = req_msg_control[7:4];
        // A high-owned word is invisible and immutable to a low requester.
        m_hidden = m_tag[m_ix] && !req_domain;
        m_rd     = 32'h0;
        if (m_t == 3'd0 && !m_hidden) m_rd = m_mem[m_ix];
        if ((m_t == 3'd1 && !m_hidden) || m_t == 3'd2) begin
          m_mem[m_ix] = req_msg_data;
          m_tag[m_ix] = req_domain;
        end
        mq.push_back('{ctl: {m_t, req_msg_control[41:34], req_msg_control[1:0]},
                       data: m_rd, dom: req_domain});
      end
    end
  end

  // Starts at posedge+1; returns at posedge+1 right after the request fired.
  task automatic issue(input logic [2:0] t, input logic [7:0] o, input logic [31:0] ad,
                       input logic [31:0] dt, input logic dm, input logic [1:0] l);
    int n;
    req_msg_control = {t, o, ad, l};
    req_msg_data    = dt;
    req_domain      = dm;
    req_val         = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_rdy) break;
    end
    if (n == 50) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: got req_rdy 0 expected 1 for opaque %0h", o);
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic check_log(input logic [12:0] ec, input logic [31:0] ed, input logic edm);
    int n;
    for (n = 0; n < 20; n++) begin
      if (log_ctl.size() > rix) break;
      @(negedge clk);
    end
    if (log_ctl.size() > rix) begin
      check("log_ctl", log_ctl[rix], ec);
      check("log_data", log_data[rix], ed);
      check("log_dom", log_dom[rix], edm);
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL resp_timeout: got %0d responses expected more than %0d", log_ctl.size(), rix);
    end
    rix++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_val = 1'b0;
    req_msg_control = '0;
    req_msg_data = '0;
    req_domain = 1'b0;
    resp_rdy = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ctl", resp_msg_control, 13'h0);
    check("reset_data", resp_msg_data, 32'h0);
    check("reset_dom", resp_domain, 1'b0);
    check("reset_val", resp_val, 1'b0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Init then read back, plus domain isolation and dropped write
    issue(3'd2, 8'h05, 32'h8, 32'hDEADBEEF, 1'b0, 2'd0);
    check("init_latency_val", resp_val, 1'b1);
    check_log(rc(3'd2, 8'h05, 2'd0), 32'h0, 1'b0);
    issue(3'd0, 8'h06, 32'h8, 32'h0, 1'b0, 2'd3);
    check_log(rc(3'd0, 8'h06, 2'd3), 32'hDEADBEEF, 1'b0);
    issue(3'd2, 8'h07, 32'h4, 32'h12345678, 1'b1, 2'd0);
    check_log(rc(3'd2, 8'h07, 2'd0), 32'h0, 1'b1);
    issue(3'd0, 8'h08, 32'h4, 32'h0, 1'b0, 2'd0);
    check_log(rc(3'd0, 8'h08, 2'd0), 32'h0, 1'b0);
    issue(3'd0, 8'h09, 32'h4, 32'h0, 1'b1, 2'd0);
    check_log(rc(3'd0, 8'h09, 2'd0), 32'h12345678, 1'b1);
    issue(3'd1, 8'h0A, 32'h4, 32'hFFFFFFFF, 1'b0, 2'd0);
    check_log(rc(3'd1, 8'h0A, 2'd0), 32'h0, 1'b0);
    issue(3'd0, 8'h0B, 32'h4, 32'h0, 1'b1, 2'd0);
    check_log(rc(3'd0, 8'h0B, 2'd0), 32'h12345678, 1'b1);
    issue(3'd5, 8'h0C, 32'h0, 32'h55, 1'b0, 2'd1);
    check_log(rc(3'd5, 8'h0C, 2'd1), 32'h0, 1'b0);
    // Upper address bits and byte offset alias onto word 2
    issue(3'd0, 8'h0D, 32'h4B, 32'h0, 1'b0, 2'd0);
    check_log(rc(3'd0, 8'h0D, 2'd0), 32'hDEADBEEF, 1'b0);
    issue(3'd0, 8'h0E, 32'hFFFFFF88, 32'h0, 1'b1, 2'd0);
    check_log(rc(3'd0, 8'h0E, 2'd0), 32'hDEADBEEF, 1'b1);
    issue(3'd1, 8'h0F, 32'h8, 32'hCAFEF00D, 1'b1, 2'd0);
    check_log(rc(3'd1, 8'h0F, 2'd0), 32'h0, 1'b1);
    issue(3'd0, 8'h10, 32'h8, 32'h0, 1'b0, 2'd0);
    check_log(rc(3'd0, 8'h10, 2'd0), 32'h0, 1'b0);
    issue(3'd0, 8'h11, 32'h8, 32'h0, 1'b1, 2'd0);
    check_log(rc(3'd0, 8'h11, 2'd0), 32'hCAFEF00D, 1'b1);

    // Backpressure: two accepted, third stalls, outputs hold the head
    resp_rdy = 1'b0;
    issue(3'd0, 8'h01, 32'h8, 32'h0, 1'b1, 2'd0);
    issue(3'd0, 8'h02, 32'h8, 32'h0, 1'b1, 2'd0);
    req_msg_control = {3'd0, 8'h03, 32'h8, 2'd0};
    req_domain = 1'b1;
    req_val = 1'b1;
    @(negedge clk);
    check("bp_full_rdy", req_rdy, 1'b0);
    check("bp_head_op", resp_msg_control[9:2], 8'h01);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_hold_op", resp_msg_control[9:2], 8'h01);
      check("bp_hold_rdy", req_rdy, 1'b0);
    end
    @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    @(negedge clk);
    check("bp_rdy_pop_cycle", req_rdy, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_rdy_after_pop", req_rdy, 1'b1);
    @(posedge clk);
    #1;
    req_val = 1'b0;
    check_log(rc(3'd0, 8'h01, 2'd0), 32'hCAFEF00D, 1'b1);
    check_log(rc(3'd0, 8'h02, 2'd0), 32'hCAFEF00D, 1'b1);
    check_log(rc(3'd0, 8'h03, 2'd0), 32'hCAFEF00D, 1'b1);

    // Throughput: one request per cycle, one response per cycle
    for (int i = 0; i < 10; i++) begin
      req_msg_control = {3'd0, 8'(8'h20 + i), 32'h8, 2'd0};
      req_domain = 1'b1;
      req_val = 1'b1;
      @(negedge clk);
      check("thru_rdy", req_rdy, 1'b1);
      @(posedge clk);
      #1;
    end
    req_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("thru_count", log_ctl.size(), rix + 10);
    if (log_cyc.size() >= rix + 10) begin
      for (int k = 1; k < 10; k++) begin
        check("thru_consecutive", log_cyc[rix + k] - log_cyc[rix + k - 1], 1);
        check("thru_op", log_ctl[rix + k][9:2], 8'h20 + k);
      end
    end
    rix = log_ctl.size();

    // Asynchronous reset with two responses queued
    resp_rdy = 1'b0;
    issue(3'd0, 8'h31, 32'h8, 32'h0, 1'b1, 2'd0);
    issue(3'd0, 8'h32, 32'h8, 32'h0, 1'b1, 2'd0);
    check("pre_rst_val", resp_val, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_val", resp_val, 1'b0);
    check("async_rst_ctl", resp_msg_control, 13'h0);
    check("async_rst_rdy", req_rdy, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    issue(3'd0, 8'h33, 32'h8, 32'h0, 1'b1, 2'd0);
    check_log(rc(3'd0, 8'h33, 2'd0), 32'h0, 1'b1);
    issue(3'd0, 8'h34, 32'h4, 32'h0, 1'b1, 2'd0);
    check_log(rc(3'd0, 8'h34, 2'd0), 32'h0, 1'b1);
    check("post_rst_total", log_ctl.size(), rix);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_mem_bank_responder_sep.md
Name: plab5_mcore_mem_bank_responder_sep

Overview:
- Memory-bank endpoint at the cache/mem side of the split control/data memory request/response network.
- Consumes request messages delivered as control and data halves plus a 1-bit domain tag.
- Services them against a small domain-tagged word store.
- Returns split-format response messages carrying the domain, with a 2-entry response queue for full throughput.

Parameters:
p_mem_opaque_nbits, 8, opaque field width (o)
p_mem_addr_nbits, 32, address width (a)
p_mem_data_nbits, 32, data width (d); must be 32
p_num_words, 16, words of storage (power of 2, >=2); idx width iw = $clog2(p_num_words)
Derived: rqc = 3+o+a+2 (45 at defaults); rsc = 3+o+2 (13 at defaults)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req_msg_control  input  rqc  {type[2:0], opaque, addr, len[1:0]}, MSB first
req_msg_data  input  d  request write data
req_domain  input  1  requester domain (0=low, 1=high)
req_val  input  1  request valid
req_rdy  output  1  request ready
resp_msg_control  output  rsc  {type[2:0], opaque, len[1:0]}
resp_msg_data  output  d  response data
resp_domain  output  1  domain of head response
resp_val  output  1  response valid
resp_rdy  input  1  response ready

Behaviour:
- Reset (reset==0, async):
  - Queue count=0, resp_val=0, resp_domain=0, resp_msg_control=0, resp_msg_data=0.
  - All storage words and their tags cleared to 0.
  - Reset mid-operation discards queued responses. Requests in flight are lost and are not replayed.
- Request fire when req_val && req_rdy. Response pop when resp_val && resp_rdy.
- req_rdy = (count<2) || (count==2 && resp_rdy) is forbidden: req_rdy = (count<2) only. It is registered-state derived, with no combinational path from resp_rdy.
- Index = addr[iw+1:2]. Address bits above and addr[1:0] are ignored. len is echoed unchanged; only full-word access is supported.
- Type 0 (read):
  - resp data = mem[idx] if tag[idx]<=req_domain, else 32'h0. A low read of a high-owned word returns zero.
  - Storage is unchanged.
- Type 1 (write):
  - If tag[idx]<=req_domain, mem[idx]<=data and tag[idx]<=req_domain.
  - Otherwise the write is dropped: a low write must not overwrite high data.
  - resp data = 0 in both cases.
- Type 2 (init): mem[idx]<=data, tag[idx]<=req_domain unconditionally. resp data = 0.
- Types 3-7: no storage effect. A response is still generated with the echoed type and data 0.
- Response entry = {type, opaque, len, data, domain=req_domain}. Response domain always equals request domain.
- Latency: request fired in cycle N enqueues at edge ending N. resp_val is visible in N+1 if the queue was empty.
- Storage is updated at the same edge as the enqueue. A read in cycle N+1 to the same idx observes the write from cycle N (no hazard).
- Queue: 2-entry FIFO with head/tail pointer wrap at 2. Outputs are driven from the head entry and are registered.
- Simultaneous enqueue+dequeue: count unchanged, order preserved.
- When count==0, resp outputs hold their last value but resp_val=0.
- Full (count==2): req_rdy=0. A pop that cycle raises req_rdy in the next cycle.
- resp_* must stay stable while resp_val && !resp_rdy.

Test Plan:
- Reset then write: init domain 0, addr 0x8, data 0xDEADBEEF, opaque 0x5 -> resp type 2, opaque 0x5, data 0, domain 0, one cycle later. Then read addr 0x8 domain 0 -> data 0xDEADBEEF.
- Cross-domain read: init addr 0x4 domain 1 data 0x12345678.
  - Read domain 0 -> data 0x0, resp_domain 0.
  - Read domain 1 -> 0x12345678, resp_domain 1.
- Dropped write: after the above, write domain 0 addr 0x4 data 0xFFFFFFFF -> resp type 1. A subsequent domain-1 read still returns 0x12345678.
- Backpressure: resp_rdy=0, issue 3 back-to-back reads (opaque 1,2,3) -> req_rdy falls after 2 accepts and resp outputs hold opaque 1. Then resp_rdy=1 -> opaques 1,2,3 in order; req_rdy returns the cycle after the first pop.
- Throughput: resp_rdy=1, req_val held 10 cycles -> 10 responses on consecutive cycles, count never exceeds 1.
- Async reset asserted mid-stream with 2 queued -> resp_val=0 immediately (no clock edge). After release, a read of the previously written addr returns 0.
